// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RV64I execute-stage ALU issue block.
// Contains the default datapath width, the ALU control codes, the major-opcode constants,
// the operand-select enums, and a helper that maps funct3/funct7[5] to an ALU control code.
package riscv_core_pkg;

  localparam int unsigned XlenDefault = 64;

  // ALU control codes
  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSrl  = 4'b1111;

  // Major opcodes
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;

  typedef enum logic [1:0] {SrcARs1, SrcAPc, SrcAZero} src_a_sel_e;
  typedef enum logic [1:0] {SrcBRs2, SrcBImm, SrcBZero} src_b_sel_e;

  // sub_en is set only for register-register forms; immediate forms never encode SUB.
  function automatic logic [3:0] alu_ctrl(input logic [2:0] funct3,
                                          input logic       funct7_b5,
                                          input logic       sub_en);
    logic [3:0] ctrl;
    ctrl = AluAdd;
    unique case (funct3)
      3'b000: ctrl = (sub_en && funct7_b5) ? AluSub : AluAdd;
      3'b001: ctrl = AluSll;
      3'b010: ctrl = AluSlt;
      3'b011: ctrl = AluSltu;
      3'b100: ctrl = AluXor;
      3'b101: ctrl = funct7_b5 ? AluSra : AluSrl;
      3'b110: ctrl = AluOr;
      3'b111: ctrl = AluAnd;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/riscv_core_alu_decode.sv
// Combinational opcode/funct decode for the ALU issue stage.
// Configuration: RISCV_ALU_WORD_OPS_EN enables decode of OP-32 / OP-IMM-32; when undefined those
// opcodes are reported illegal and alu_isword_o stays 0.
// Ports:
//   opcode_i, funct3_i, funct7_b5_i : instruction fields
//   alu_control_o, alu_isword_o     : ALU control code and 32-bit word flag
//   src_a_sel_o, src_b_sel_o        : operand source selects
//   illegal_o                       : unsupported opcode/funct3
module riscv_core_alu_decode
  import riscv_core_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_b5_i,
  output logic [3:0]  alu_control_o,
  output logic        alu_isword_o,
  output src_a_sel_e  src_a_sel_o,
  output src_b_sel_e  src_b_sel_o,
  output logic        illegal_o
);

`ifdef RISCV_ALU_WORD_OPS_EN
  logic word_f3_ok;
  assign word_f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b101);
`endif

  always_comb begin
    // Defaults are also the illegal-op drive: ADD with zero operands.
    alu_control_o = AluAdd;
    alu_isword_o  = 1'b0;
    src_a_sel_o   = SrcAZero;
    src_b_sel_o   = SrcBZero;
    illegal_o     = 1'b0;
    case (opcode_i)
      OpcOp: begin
        src_a_sel_o   = SrcARs1;
        src_b_sel_o   = SrcBRs2;
        alu_control_o = alu_ctrl(funct3_i, funct7_b5_i, 1'b1);
      end
      OpcOpImm: begin
        src_a_sel_o   = SrcARs1;
        src_b_sel_o   = SrcBImm;
        alu_control_o = alu_ctrl(funct3_i, funct7_b5_i, 1'b0);
      end
      OpcLui: begin
        src_a_sel_o = SrcAZero;
        src_b_sel_o = SrcBImm;
      end
      OpcAuipc: begin
        src_a_sel_o = SrcAPc;
        src_b_sel_o = SrcBImm;
      end
`ifdef RISCV_ALU_WORD_OPS_EN
      OpcOp32: begin
        if (word_f3_ok) begin
          src_a_sel_o   = SrcARs1;
          src_b_sel_o   = SrcBRs2;
          alu_isword_o  = 1'b1;
          alu_control_o = alu_ctrl(funct3_i, funct7_b5_i, 1'b1);
        end else begin
          illegal_o = 1'b1;
        end
      end
      OpcOpImm32: begin
        if (word_f3_ok) begin
          src_a_sel_o   = SrcARs1;
          src_b_sel_o   = SrcBImm;
          alu_isword_o  = 1'b1;
          alu_control_o = alu_ctrl(funct3_i, funct7_b5_i, 1'b0);
        end else begin
          illegal_o = 1'b1;
        end
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_core_alu_issue.sv
// Execute-stage issue and capture pipeline for the RV64I core.
// S1 registers decoded operands/control and drives the external combinational ALU; S2 captures
// the ALU result, rd and illegal flag for the memory stage. Both ends use valid/ready.
// Configuration: RISCV_ALU_WORD_OPS_EN enables OP-32 / OP-IMM-32 (decoded in riscv_core_alu_decode).
// Ports:
//   i_clk, i_rst (sync, active-high)
//   upstream  : i_valid, o_ready, i_opcode, i_funct3, i_funct7_b5, i_rs1, i_rs2, i_imm, i_pc, i_rd
//   ALU       : o_alu_srcA, o_alu_srcB, o_alu_control, o_alu_isword, i_alu_result
//   downstream: o_valid, i_out_ready, o_result, o_rd, o_illegal
module riscv_core_alu_issue
  import riscv_core_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7_b5,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_rd,
  output logic [XLEN-1:0] o_alu_srcA,
  output logic [XLEN-1:0] o_alu_srcB,
  output logic [3:0]      o_alu_control,
  output logic            o_alu_isword,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_illegal
);

  logic [3:0]  dec_ctrl;
  logic        dec_isword;
  src_a_sel_e  dec_a_sel;
  src_b_sel_e  dec_b_sel;
  logic        dec_illegal;

  riscv_core_alu_decode u_decode (
    .opcode_i      (i_opcode),
    .funct3_i      (i_funct3),
    .funct7_b5_i   (i_funct7_b5),
    .alu_control_o (dec_ctrl),
    .alu_isword_o  (dec_isword),
    .src_a_sel_o   (dec_a_sel),
    .src_b_sel_o   (dec_b_sel),
    .illegal_o     (dec_illegal)
  );

  // S1: operand stage
  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_src_a_q, s1_src_a_d;
  logic [XLEN-1:0] s1_src_b_q, s1_src_b_d;
  logic [3:0]      s1_ctrl_q, s1_ctrl_d;
  logic            s1_isword_q, s1_isword_d;
  logic [4:0]      s1_rd_q, s1_rd_d;
  logic            s1_illegal_q, s1_illegal_d;

  // S2: result stage
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_illegal_q, out_illegal_d;

  logic            s1_load;
  logic            s2_load;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  // S1 may accept when it is empty, or when its content can move into S2 this cycle.
  assign o_ready = !s1_valid_q || !out_valid_q || i_out_ready;
  assign s1_load = i_valid && o_ready;
  assign s2_load = s1_valid_q && (!out_valid_q || i_out_ready);

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (dec_a_sel)
      SrcARs1: op_a = i_rs1;
      SrcAPc:  op_a = i_pc;
      default: op_a = '0;
    endcase
    case (dec_b_sel)
      SrcBRs2: op_b = i_rs2;
      SrcBImm: op_b = i_imm;
      default: op_b = '0;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_src_a_d   = s1_src_a_q;
    s1_src_b_d   = s1_src_b_q;
    s1_ctrl_d    = s1_ctrl_q;
    s1_isword_d  = s1_isword_q;
    s1_rd_d      = s1_rd_q;
    s1_illegal_d = s1_illegal_q;

    if (s1_load) begin
      s1_valid_d   = 1'b1;
      s1_src_a_d   = op_a;
      s1_src_b_d   = op_b;
      s1_ctrl_d    = dec_ctrl;
      // Decoder holds this low when word ops are compiled out.
      s1_isword_d  = dec_isword;
      s1_rd_d      = i_rd;
      s1_illegal_d = dec_illegal;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;

    if (s2_load) begin
      out_valid_d   = 1'b1;
      out_result_d  = s1_illegal_q ? '0 : i_alu_result;
      out_rd_d      = s1_rd_q;
      out_illegal_d = s1_illegal_q;
    end else if (i_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q    <= 1'b0;
      s1_src_a_q    <= '0;
      s1_src_b_q    <= '0;
      s1_ctrl_q     <= AluAdd;
      s1_isword_q   <= 1'b0;
      s1_rd_q       <= '0;
      s1_illegal_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_src_a_q    <= s1_src_a_d;
      s1_src_b_q    <= s1_src_b_d;
      s1_ctrl_q     <= s1_ctrl_d;
      s1_isword_q   <= s1_isword_d;
      s1_rd_q       <= s1_rd_d;
      s1_illegal_q  <= s1_illegal_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign o_alu_srcA    = s1_src_a_q;
  assign o_alu_srcB    = s1_src_b_q;
  assign o_alu_control = s1_ctrl_q;
  assign o_alu_isword  = s1_isword_q;
  assign o_valid       = out_valid_q;
  assign o_result      = out_result_q;
  assign o_rd          = out_rd_q;
  assign o_illegal     = out_illegal_q;

endmodule

// File: tb/tb_riscv_core_alu_issue.sv
// Bench for riscv_core_alu_issue: models the external ALU, drives instructions over the upstream
// handshake and checks results against a scoreboard of expected values.
module tb_riscv_core_alu_issue;
  import riscv_core_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [6:0]      i_opcode;
  logic [2:0]      i_funct3;
  logic            i_funct7_b5;
  logic [XLEN-1:0] i_rs1, i_rs2, i_imm, i_pc;
  logic [4:0]      i_rd;
  logic [XLEN-1:0] o_alu_srcA, o_alu_srcB;
  logic [3:0]      o_alu_control;
  logic            o_alu_isword;
  logic [XLEN-1:0] alu_result;
  logic            o_valid;
  logic            i_out_ready;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;
  logic            o_illegal;

  always #5 clk = ~clk;

  riscv_core_alu_issue #(.XLEN(XLEN)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_opcode      (i_opcode),
    .i_funct3      (i_funct3),
    .i_funct7_b5   (i_funct7_b5),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_imm         (i_imm),
    .i_pc          (i_pc),
    .i_rd          (i_rd),
    .o_alu_srcA    (o_alu_srcA),
    .o_alu_srcB    (o_alu_srcB),
    .o_alu_control (o_alu_control),
    .o_alu_isword  (o_alu_isword),
    .i_alu_result  (alu_result),
    .o_valid       (o_valid),
    .i_out_ready   (i_out_ready),
    .o_result      (o_result),
    .o_rd          (o_rd),
    .o_illegal     (o_illegal)
  );

  // Behavioural ALU on the receiving end of the ALU interface.
  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] ctrl, input logic isword);
    logic [63:0] r;
    logic [31:0] w;
    r = '0;
    w = '0;
    if (isword) begin
      case (ctrl)
        AluAdd:  w = a[31:0] + b[31:0];
        AluSub:  w = a[31:0] - b[31:0];
        AluSll:  w = a[31:0] << b[4:0];
        AluSrl:  w = a[31:0] >> b[4:0];
        AluSra:  w = $unsigned($signed(a[31:0]) >>> b[4:0]);
        default: w = '0;
      endcase
      r = {{32{w[31]}}, w};
    end else begin
      case (ctrl)
        AluAdd:  r = a + b;
        AluSub:  r = a - b;
        AluAnd:  r = a & b;
        AluOr:   r = a | b;
        AluXor:  r = a ^ b;
        AluSll:  r = a << b[5:0];
        AluSrl:  r = a >> b[5:0];
        AluSra:  r = $unsigned($signed(a) >>> b[5:0]);
        AluSlt:  r = {63'b0, $signed(a) < $signed(b)};
        AluSltu: r = {63'b0, a < b};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_comb alu_result = alu_model(o_alu_srcA, o_alu_srcB, o_alu_control, o_alu_isword);

  // Reference for register-register OP by funct3 (non-shift subset used by random traffic).
  function automatic logic [63:0] ref_op(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] b);
    case (f3)
      3'b000:  return a + b;
      3'b011:  return (a < b) ? 64'd1 : 64'd0;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 64'd0;
    endcase
  endfunction

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer happens on the next edge when o_valid && i_out_ready.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_out", {63'b0, o_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("result", o_result, e.res);
        check_eq("rd", {59'b0, o_rd}, {59'b0, e.rd});
        check_eq("illegal", {63'b0, o_illegal}, {63'b0, e.ill});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                      input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                      input logic [63:0] pc, input logic [4:0] rd,
                      input logic [63:0] exp_res, input logic exp_ill);
    exp_t e;
    int   n;
    i_valid     = 1'b1;
    i_opcode    = opc;
    i_funct3    = f3;
    i_funct7_b5 = b5;
    i_rs1       = rs1;
    i_rs2       = rs2;
    i_imm       = imm;
    i_pc        = pc;
    i_rd        = rd;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      check_eq("accept_timeout", {63'b0, o_ready}, 64'd1);
    end else begin
      e.res = exp_res;
      e.rd  = rd;
      e.ill = exp_ill;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addw_exp;
    logic        addw_ill;
    int          k;
    logic [2:0]  f3_tab [5];

    f3_tab = '{3'b000, 3'b011, 3'b100, 3'b110, 3'b111};

    i_rst = 1'b1;
    i_valid = 1'b0;
    i_opcode = '0;
    i_funct3 = '0;
    i_funct7_b5 = 1'b0;
    i_rs1 = '0;
    i_rs2 = '0;
    i_imm = '0;
    i_pc = '0;
    i_rd = '0;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Reset state
    check_eq("rst_o_valid", {63'b0, o_valid}, 64'd0);
    check_eq("rst_o_ready", {63'b0, o_ready}, 64'd1);
    check_eq("rst_o_result", o_result, 64'd0);
    check_eq("rst_o_rd", {59'b0, o_rd}, 64'd0);
    check_eq("rst_o_illegal", {63'b0, o_illegal}, 64'd0);
    check_eq("rst_alu_ctrl", {60'b0, o_alu_control}, {60'b0, AluAdd});
    check_eq("rst_alu_srcA", o_alu_srcA, 64'd0);
    check_eq("rst_alu_srcB", o_alu_srcB, 64'd0);
    check_eq("rst_alu_isword", {63'b0, o_alu_isword}, 64'd0);

    // ADD 5+7 and two-cycle latency
    send(OpcOp, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0, 5'd1, 64'd12, 1'b0);
    check_eq("lat_s1_valid", {63'b0, o_valid}, 64'd0);
    check_eq("lat_s1_srcA", o_alu_srcA, 64'd5);
    @(posedge clk);
    #1;
    check_eq("lat_s2_valid", {63'b0, o_valid}, 64'd1);
    check_eq("lat_s2_result", o_result, 64'd12);
    drain();

    // SUB then SRA back-to-back
    k = pop_cyc.size();
    send(OpcOp, 3'b000, 1'b1, 64'd0, 64'd4, 64'd0, 64'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(OpcOp, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 5'd3,
         64'hF800_0000_0000_0000, 1'b0);
    drain();
    if (pop_cyc.size() >= k + 2)
      check_eq("b2b_spacing", 64'(pop_cyc[k+1] - pop_cyc[k]), 64'd1);
    else
      check_eq("b2b_count", 64'(pop_cyc.size() - k), 64'd2);

    // ADDW overflow into sign bit
`ifdef RISCV_ALU_WORD_OPS_EN
    addw_exp = 64'hFFFF_FFFF_8000_0000;
    addw_ill = 1'b0;
`else
    addw_exp = 64'd0;
    addw_ill = 1'b1;
`endif
    send(OpcOp32, 3'b000, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd4, addw_exp, addw_ill);

    // AUIPC, LUI
    send(OpcAuipc, 3'b000, 1'b0, 64'd0, 64'd0, 64'h2000, 64'h1000, 5'd5, 64'h3000, 1'b0);
    send(OpcLui, 3'b000, 1'b0, 64'h55, 64'h66, 64'hFFFF_FFFF_8000_0000, 64'h4000, 5'd6,
         64'hFFFF_FFFF_8000_0000, 1'b0);

    // ADDI ignores funct7_b5; SRLI; illegal opcode; illegal word funct3
    send(OpcOpImm, 3'b000, 1'b1, 64'd10, 64'd99, 64'd3, 64'd0, 5'd7, 64'd13, 1'b0);
    send(OpcOpImm, 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'd0, 5'd8,
         64'h0800_0000_0000_0000, 1'b0);
    send(7'b0000011, 3'b000, 1'b0, 64'd1, 64'd2, 64'd3, 64'd4, 5'd9, 64'd0, 1'b1);
    send(OpcOp32, 3'b010, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd10, 64'd0, 1'b1);
    drain();

    // Random register-register traffic
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [63:0] a, b;
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      send(OpcOp, f3, 1'b0, a, b, 64'd0, 64'd0, 5'(i + 11), ref_op(f3, a, b), 1'b0);
    end
    drain();

    // Backpressure: three instructions while downstream stalls for four cycles
    i_out_ready = 1'b0;
    fork
      begin
        send(OpcOp, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd20, 64'd3, 1'b0);
        send(OpcOp, 3'b100, 1'b0, 64'hF0, 64'h0F, 64'd0, 64'd0, 5'd21, 64'hFF, 1'b0);
        send(OpcOp, 3'b110, 1'b0, 64'h100, 64'h1, 64'd0, 64'd0, 5'd22, 64'h101, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_eq("bp_valid_held", {63'b0, o_valid}, 64'd1);
          check_eq("bp_result_stable", o_result, 64'd3);
          check_eq("bp_ready_low", {63'b0, o_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    i_out_ready = 1'b0;
    send(OpcOp, 3'b000, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 5'd23, 64'd18, 1'b0);
    send(OpcOp, 3'b000, 1'b0, 64'd8, 64'd8, 64'd0, 64'd0, 5'd24, 64'd16, 1'b0);
    check_eq("full_before_rst", {63'b0, o_ready}, 64'd0);
    i_rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    check_eq("mid_rst_o_valid", {63'b0, o_valid}, 64'd0);
    check_eq("mid_rst_o_ready", {63'b0, o_ready}, 64'd1);
    i_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_idle", {63'b0, o_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
